coder_lane_arbiter: RTL and testbench

- Merges N per-lane coder byte streams into the single tagged output stream (byte, idx, last) that feeds the 80 MHz coder output port.
- Arbitration is round-robin over lanes that are valid and not finished.
- Tracks per-lane end-of-stream and asserts global last on the beat that completes the final open lane.
- Sits in the coder clock domain, between the per-lane arithmetic coders and the top-level coder_out interface.

---
 rtl/coder_lane_arbiter_pkg.sv | 26 ++
 rtl/coder_lane_arbiter_if.sv | 22 ++
 rtl/coder_lane_arbiter_rr_arbiter.sv | 16 +
 rtl/coder_lane_arbiter.sv | 92 +++++++++
 tb/tb_coder_lane_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/coder_lane_arbiter_pkg.sv
// coder_arb_pkg: shared defaults, FSM type and round-robin pick function for coder_lane_arbiter.
package coder_arb_pkg;
    localparam int N_LANES_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int LANE_W = 4;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} arb_state_t;
    typedef struct packed {
        logic found;
        logic [LANE_W-1:0] idx;
    } rr_pick_t;
    // First eligible lane scanning ptr, ptr+1, ... modulo n (n <= 16, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [15:0] eligible, input logic [LANE_W-1:0] ptr, input int unsigned n);
        rr_pick_t r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            j = 32'(ptr) + k;
            j = (j >= n) ? j - n : j;
            if (k < n && !r.found && eligible[j[3:0]]) begin
                r.found = 1'b1;
                r.idx = j[3:0];
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/coder_lane_arbiter_if.sv
// coder_lane_arbiter_if: per-lane input streams and tagged output stream of the coder lane arbiter.
interface coder_lane_arbiter_if
    import coder_arb_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W = 8
);
    logic [N_LANES-1:0] in_valid, in_last, in_ready;
    logic [N_LANES*DATA_W-1:0] in_data;
    logic out_valid, out_lane_last, out_last, out_ready, all_done;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input in_ready, out_valid, out_data, out_idx, out_lane_last, out_last, all_done
    );
    modport slave (
        input in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_lane_last, out_last, all_done
    );
endinterface

// File: rtl/coder_lane_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker over up to 16 lanes.
module rr_arbiter
    import coder_arb_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF
) (
    input  logic [N_LANES-1:0] eligible,
    input  logic [LANE_W-1:0] ptr,
    output logic [LANE_W-1:0] grant,
    output logic found
);
    rr_pick_t pick;
    always_comb pick = rr_pick(16'(eligible), ptr, N_LANES);
    assign grant = pick.idx;
    assign found = pick.found;
endmodule

// File: rtl/coder_lane_arbiter.sv
// coder_lane_arbiter: round-robin merge of per-lane coder streams into one tagged stream with end-of-stream tracking.
// Optional CODER_ARB_STATS_EN adds per-lane beat counters and an output stall counter.
module coder_lane_arbiter
    import coder_arb_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W = 8
) (
    input logic clk,
    input logic rst_n,
    coder_lane_arbiter_if.slave bus
`ifdef CODER_ARB_STATS_EN
    ,
    output logic [N_LANES*32-1:0] stat_beats,
    output logic [31:0] stat_stall
`endif
);
    arb_state_t state, state_nx;
    logic [N_LANES-1:0] lane_done, eligible, grant_oh, lane_fin;
    logic [LANE_W-1:0] rr_ptr, grant;
    logic [DATA_W-1:0] grant_data;
    logic found, slot_free, take_last, fin;

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign eligible = (!rst_n && state == RUN && slot_free) ? bus.in_valid & ~lane_done : '0;

    rr_arbiter #(.N_LANES(N_LANES)) u_rr (
        .eligible(eligible),
        .ptr(rr_ptr),
        .grant(grant),
        .found(found)
    );

    assign grant_oh = found ? N_LANES'(1) << grant : '0;
    assign bus.in_ready = grant_oh;
    assign take_last = |(grant_oh & bus.in_last);
    assign lane_fin = lane_done | (take_last ? grant_oh : '0);
    assign fin = take_last && &lane_fin;
    assign bus.all_done = state == DONE;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_LANES; i++)
            grant_data |= bus.in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_oh[i]}};
    end

    always_comb begin
        state_nx = state;
        if (state == RUN && fin) state_nx = DRAIN;
        if (state == DRAIN && bus.out_valid && bus.out_ready) state_nx = DONE;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= RUN;
            rr_ptr <= '0;
            lane_done <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_idx <= '0;
            bus.out_lane_last <= 1'b0;
            bus.out_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (found) begin
                bus.out_valid <= 1'b1;
                bus.out_data <= grant_data;
                bus.out_idx <= IDX_W'(grant);
                bus.out_lane_last <= take_last;
                bus.out_last <= fin;
                rr_ptr <= (grant == LANE_W'(N_LANES - 1)) ? '0 : grant + 1'b1;
                lane_done <= lane_fin;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef CODER_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else if (state != DONE) begin
            for (int i = 0; i < N_LANES; i++)
                if (grant_oh[i]) stat_beats[i*32 +: 32] <= stat_beats[i*32 +: 32] + 32'd1;
            if (bus.out_valid && !bus.out_ready) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_coder_lane_arbiter.sv
// tb_coder_lane_arbiter: directed stimulus with a queue-based reference model checked every cycle.
module tb_coder_lane_arbiter;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int errors = 0, checks = 0, cyc = 0, first_ad = -1, eg;
    logic [N-1:0] hs = '0, er;
    logic [8:0] q[N][$];
    logic [17:0] log_q[$];
    int log_cyc[$];
    logic [N-1:0] mdone = '0;
    int mptr = 0, midx = 0, g_m;
    bit mv = 0, mll = 0, mlast = 0, mad = 0, macc;
    logic [7:0] md = '0;

    coder_lane_arbiter_if #(.N_LANES(N), .DATA_W(8), .IDX_W(8)) bus ();
`ifdef CODER_ARB_STATS_EN
    logic [N*32-1:0] stat_beats;
    logic [31:0] stat_stall;
    coder_lane_arbiter #(.N_LANES(N), .DATA_W(8), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_beats(stat_beats), .stat_stall(stat_stall));
`else
    coder_lane_arbiter #(.N_LANES(N), .DATA_W(8), .IDX_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.out_valid, bus.out_data, bus.out_idx, bus.out_lane_last, bus.out_last, bus.in_ready, bus.all_done});
    endfunction

    // Lane granted this cycle by the rules: slot free, stream still open, first open valid lane from the pointer.
    function automatic int pick();
        if (rst_n || &mdone || (mv && !bus.out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            int j = (mptr + k) % N;
            if (bus.in_valid[j] && !mdone[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mdone = '0; mptr = 0; mv = 0; md = '0; midx = 0; mll = 0; mlast = 0; mad = 0;
        end else begin
            macc = mv && bus.out_ready && mlast;
            g_m = pick();
            if (g_m >= 0) begin
                mv = 1;
                md = bus.in_data[g_m*8 +: 8];
                midx = g_m;
                mll = bus.in_last[g_m];
                if (mll) mdone[g_m] = 1'b1;
                mlast = mll && (&mdone);
                mptr = (g_m + 1) % N;
            end else if (bus.out_ready) begin
                mv = 0;
            end
            if (macc) mad = 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        eg = pick();
        er = (eg >= 0) ? N'(1) << eg : '0;
        chk("cycle", 64'({bus.out_valid, bus.in_ready, bus.all_done}), 64'({mv, er, mad}));
        if (mv) chk("beat", 64'({bus.out_data, bus.out_idx, bus.out_lane_last, bus.out_last}), 64'({md, 8'(midx), mll, mlast}));
        if (rst_n) begin
            log_q.delete();
            log_cyc.delete();
            first_ad = -1;
        end else if (bus.out_valid && bus.out_ready) begin
            log_q.push_back({bus.out_last, bus.out_lane_last, bus.out_idx, bus.out_data});
            log_cyc.push_back(cyc);
        end
        if (bus.all_done && first_ad < 0) first_ad = cyc;
        hs = bus.in_ready;
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.in_valid[i] = q[i].size() > 0;
            bus.in_last[i] = q[i].size() > 0 && q[i][0][8];
            bus.in_data[i*8 +: 8] = q[i].size() > 0 ? q[i][0][7:0] : 8'h00;
        end
    endtask

    task automatic step(input bit ordy);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
        bus.out_ready = ordy;
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        bus.out_ready = 1'b0;
        drive();
        rst_n = 1'b1;
        #1 chk("reset_outs", outs(), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        int nll, nl, nff, n2;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.in_last = '0;
        bus.out_ready = 1'b0;

        // single lane
        do_reset();
        q[0].push_back({1'b0, 8'h11});
        q[0].push_back({1'b0, 8'h22});
        q[0].push_back({1'b1, 8'h33});
        bus.out_ready = 1'b1;
        drive();
        repeat (6) step(1);
        chk("single_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("single_b0", log_q[0], {2'b00, 8'h00, 8'h11});
            chk("single_b2", log_q[2], {2'b01, 8'h00, 8'h33});
        end
        chk("single_all_done", bus.all_done, 0);

        // fairness
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) q[i].push_back({1'b0, 8'(i*16 + k)});
        bus.out_ready = 1'b1;
        drive();
        repeat (12) step(1);
        chk("fair_n", log_q.size(), 11);
        if (log_q.size() >= 10) begin
            for (int k = 0; k < 10; k++) chk("fair_idx", log_q[k][15:8], k % 8);
            chk("fair_d8", log_q[8][7:0], 8'h01);
            chk("fair_d9", log_q[9][7:0], 8'h11);
        end

        // backpressure
        do_reset();
        q[3].push_back({1'b0, 8'hA5});
        q[3].push_back({1'b0, 8'h5A});
        drive();
        step(0);
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_hold", 64'({bus.out_valid, bus.out_data, bus.out_idx, bus.in_ready}), 64'({1'b1, 8'hA5, 8'h03, 8'h00}));
            step(0);
        end
        repeat (3) step(1);
        chk("bp_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("bp_first", log_q[0], {2'b00, 8'h03, 8'hA5});
            chk("bp_second", log_q[1], {2'b00, 8'h03, 8'h5A});
        end

        // completion with intermittent backpressure
        do_reset();
        for (int i = 0; i < N; i++) begin
            q[i].push_back({1'b0, 8'(i*16 + 1)});
            q[i].push_back({1'b1, 8'(i*16 + 2)});
        end
        drive();
        for (int k = 0; k < 80 && !bus.all_done; k++) step(k % 3 != 2);
        q[0].push_back({1'b0, 8'h77});
        drive();
        repeat (3) step(1);
        nll = 0;
        nl = 0;
        foreach (log_q[k]) begin
            nll += int'(log_q[k][16]);
            nl += int'(log_q[k][17]);
        end
        chk("done_beats", log_q.size(), 16);
        chk("done_lane_lasts", nll, 8);
        chk("done_lasts", nl, 1);
        if (log_q.size() == 16) begin
            chk("done_last_pos", log_q[15][17], 1);
            chk("done_delay", first_ad - log_cyc[15], 1);
        end
        #1;
        chk("done_flag", bus.all_done, 1);
        chk("done_ready", bus.in_ready, 0);

        // finished lane ignored
        do_reset();
        q[2].push_back({1'b0, 8'h21});
        q[2].push_back({1'b1, 8'h22});
        q[2].push_back({1'b0, 8'hFF});
        for (int k = 1; k <= 6; k++) q[5].push_back({1'b0, 8'(80 + k)});
        bus.out_ready = 1'b1;
        drive();
        repeat (10) step(1);
        nff = 0;
        n2 = 0;
        foreach (log_q[k])
            if (log_q[k][15:8] == 8'd2) begin
                n2++;
                if (log_q[k][7:0] == 8'hFF) nff++;
            end
        chk("ignored_ff", nff, 0);
        chk("lane2_beats", n2, 2);
        #1 chk("lane2_ready", bus.in_ready[2], 0);

        // reset mid-stream
        do_reset();
        q[0].push_back({1'b1, 8'h01});
        q[0].push_back({1'b0, 8'h02});
        for (int i = 1; i < N; i++)
            for (int k = 0; k < 4; k++) q[i].push_back({1'b0, 8'(i*16 + k)});
        bus.out_ready = 1'b1;
        drive();
        for (int k = 0; k < 20 && log_q.size() < 5; k++) step(1);
        step(0);
        #1 chk("mid_held", bus.out_valid, 1);
        #1 rst_n = 1'b1;
        #1 chk("rst_async", outs(), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        repeat (3) step(1);
        chk("restart_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("restart_lane0", log_q[0], {2'b00, 8'h00, 8'h02});
            chk("restart_lane1", log_q[1], {2'b00, 8'h01, 8'h11});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
